// File: rtl/maxnet_io_buffer.sv
// maxnet_io_buffer: collects four opaque sample words for the MAXNET neuron
// datapath, pulses start, waits for the datapath result and presents it
// downstream with a valid/ready handshake.
// Optional feature: define MAXNET_IO_TIMEOUT_EN to bound the WAIT state by
// TIMEOUT cycles (abort with err=1 and a zero result).
module maxnet_io_buffer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic              start,
  input  logic              done,
  input  logic [DATA_W-1:0] res,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] cnt;
  logic       accept;
  logic       out_fire;
  logic       timeout_hit;

  assign accept   = in_valid && (state == FILL);
  assign out_fire = out_ready && (state == OUT);

`ifdef MAXNET_IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && !done && (wait_cnt == TW'(TIMEOUT - 1));

  // Count consecutive WAIT cycles; any exit from WAIT restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && (next_state == WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Error flag raised on abort and held until the aborted result is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end else if (out_fire) begin
      err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == 2'd3)) begin
          next_state = START;
        end
      end
      START: begin
        start      = 1'b1;
        busy       = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (done || timeout_hit) begin
          next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = FILL;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Sample slots are written only while filling, so they stay frozen from START through OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      x0  <= '0;
      x1  <= '0;
      x2  <= '0;
      x3  <= '0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    x0 <= in_data;
        2'd1:    x1 <= in_data;
        2'd2:    x2 <= in_data;
        default: x3 <= in_data;
      endcase
    end else if (out_fire) begin
      cnt <= 2'd0;
    end
  end

  // Result capture: datapath result on done, zero on abort; held through OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (state == WAIT) begin
      if (done) begin
        out_data <= res;
      end else if (timeout_hit) begin
        out_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_maxnet_io_buffer.sv
// Testbench for maxnet_io_buffer: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_maxnet_io_buffer;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x0, x1, x2, x3;
  logic          start;
  logic          done;
  logic [DW-1:0] res;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_x [4];
  logic [DW-1:0] words [4];

  maxnet_io_buffer #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .start(start), .done(done), .res(res),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slots(input string tag);
    check({tag, "_x0"}, x0, exp_x[0]);
    check({tag, "_x1"}, x1, exp_x[1]);
    check({tag, "_x2"}, x2, exp_x[2]);
    check({tag, "_x3"}, x3, exp_x[3]);
  endtask

  // Offer one word in FILL and advance past the accepting edge
  task automatic push(input logic [DW-1:0] d);
    check("fill_in_ready", in_ready, 1);
    check("fill_no_start", start, 0);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Four accepts with random idle gaps and stray done pulses; ends in START
  task automatic fill4(input int idle_max);
    for (int i = 0; i < 4; i++) begin
      int idle;
      idle = $urandom_range(0, idle_max);
      for (int k = 0; k < idle; k++) begin
        done = 1'($urandom_range(0, 1));
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_no_out_valid", out_valid, 0);
      end
      done = 1'b0;
      push(words[i]);
      exp_x[i] = words[i];
    end
    check("start_pulse", start, 1);
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 0);
    check_slots("start");
  endtask

  // From WAIT: optional idle cycles, done with a result, stalled output, handshake
  task automatic wait_result(input logic [DW-1:0] r, input int wait_k, input int stall_k);
    for (int k = 0; k < wait_k; k++) begin
      tick();
      check("wait_no_out_valid", out_valid, 0);
      check("wait_busy", busy, 1);
    end
    done = 1'b1;
    res  = r;
    tick();
    done = 1'b0;
    res  = $urandom;
    check("result_valid", out_valid, 1);
    check("result_data", out_data, r);
    check("result_not_busy", busy, 0);
    check("result_no_err", err, 0);
    check_slots("result");
    out_ready = 1'b0;
    for (int k = 0; k < stall_k; k++) begin
      done = 1'b1;
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, r);
    end
    done      = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handshake_valid_clear", out_valid, 0);
    check("handshake_in_ready", in_ready, 1);
    check_slots("after_handshake");
  endtask

  // From START: stray done/in_valid are ignored, then the result phase
  task automatic finish_txn(input logic [DW-1:0] r, input int wait_k, input int stall_k);
    done     = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    tick();
    done     = 1'b0;
    in_valid = 1'b0;
    check("start_one_cycle", start, 0);
    check("wait_busy_entry", busy, 1);
    check("done_in_start_ignored", out_valid, 0);
    check("wait_in_ready", in_ready, 0);
    check_slots("wait_entry");
    wait_result(r, wait_k, stall_k);
  endtask

  initial begin
    int accepts;
    logic [DW-1:0] gap_words [$];
    logic          pat [7];

    rst = 1'b1; in_data = '0; in_valid = 1'b0; done = 1'b0; res = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_x[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_x0", x0, 0);
    check("rst_x3", x3, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Back-to-back fill 5, 9, 2, 7 and result 9 with a 3-cycle output stall
    words[0] = 5; words[1] = 9; words[2] = 2; words[3] = 7;
    fill4(0);
    finish_txn(9, 0, 3);

    // Gapped valid pattern: 1,0,1,0,1,1,1 gives exactly four accepts
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      logic [DW-1:0] d;
      d        = 32'h100 + DW'(c);
      in_valid = pat[c];
      in_data  = d;
      done     = (c == 1);
      if (pat[c] && accepts < 4) begin
        gap_words.push_back(d);
        accepts++;
      end
      tick();
      check("gap_start", start, (pat[c] && accepts == 4 && gap_words.size() == 4 && c == 5) ? 1 : 0);
      check("gap_no_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 4; i++) exp_x[i] = gap_words[i];
    check("gap_accept_count", DW'(gap_words.size()), 4);
    check_slots("gap");
    check("gap_in_wait_busy", busy, 1);
    wait_result(32'hABCD_0123, 1, 1);

    // Asynchronous reset after two accepts discards the partial fill
    push(21);
    push(22);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_x[i] = '0;
    check_slots("midrst");
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_start", start, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    push(11);
    check("midrst_first_x0", x0, 11);
    check("midrst_x1_clear", x1, 0);
    words[0] = 11; words[1] = 12; words[2] = 13; words[3] = 14;
    exp_x[0] = 11;
    for (int i = 1; i < 4; i++) begin
      push(words[i]);
      exp_x[i] = words[i];
    end
    check("midrst_start", start, 1);
    check_slots("midrst_fill");
    finish_txn(14, 0, 0);

    // WAIT with done held low
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    fill4(1);
    tick();
    check("to_wait_entry", busy, 1);
`ifdef MAXNET_IO_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      check("to_pending", out_valid, 0);
    end
    tick();
    check("to_out_valid", out_valid, 1);
    check("to_out_data", out_data, 0);
    check("to_err", err, 1);
    tick();
    check("to_err_hold", err, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("to_err_clear", err, 0);
    check("to_in_ready", in_ready, 1);
`else
    for (int k = 0; k < 3 * TO; k++) begin
      tick();
      check("nto_stays_wait", out_valid, 0);
      check("nto_err", err, 0);
    end
    check("nto_busy", busy, 1);
    wait_result(32'h5A5A_A5A5, 0, 0);
`endif

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      fill4(2);
      finish_txn($urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
